line_memory: RTL and testbench

- Responder (memory side) of the line-granular request/response protocol driven by the data cache.
- Accepts one line read or line write at a time, models fixed access latency, returns a full line on reads.
- Sits below the cache as the backing store.
- Timing matches the cache's handshake:
  - is_input_valid/mem_ready to accept a request.
  - one-cycle is_output_valid pulse to return read data.

---
 rtl/line_memory_pkg.sv | 13 +
 rtl/line_store.sv | 44 ++++
 rtl/line_memory.sv | 110 +++++++++++
 tb/tb_line_memory.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/line_memory_pkg.sv
// Shared types and default geometry for the line-granular backing store.
package line_memory_pkg;

  typedef enum logic [1:0] {StIdle, StBusy, StRespond} state_e;

  localparam int unsigned DefBlockSize = 16;
  localparam int unsigned DefNumLines  = 256;
  localparam int unsigned DefOffsetW   = $clog2(DefBlockSize);
  localparam int unsigned DefIndexW    = $clog2(DefNumLines);

  typedef logic [DefBlockSize*8-1:0] line_t;

endpackage

// File: rtl/line_store.sv
// Line storage array: one synchronous write port and one registered read port.
module line_store #(
  parameter int unsigned NumLines = 256,
  parameter int unsigned Width    = 128,
  localparam int unsigned AddrW   = $clog2(NumLines)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [NumLines];
  logic [Width-1:0] rdata_q, rdata_d;

  // Contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem_q[raddr_i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/line_memory.sv
// Fixed-latency line memory responder; one outstanding read or write at a time.
module line_memory
  import line_memory_pkg::*;
#(
  parameter int unsigned BLOCK_SIZE = DefBlockSize,
  parameter int unsigned NUM_LINES  = DefNumLines,
  parameter int unsigned DELAY      = 50
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    is_input_valid,
  input  logic [31:0]             addr,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [BLOCK_SIZE*8-1:0] din,
  output logic                    is_output_valid,
  output logic [BLOCK_SIZE*8-1:0] dout,
  output logic                    mem_ready
);

  localparam int unsigned OffW  = $clog2(BLOCK_SIZE);
  localparam int unsigned IdxW  = $clog2(NUM_LINES);
  localparam int unsigned LineW = BLOCK_SIZE * 8;
  localparam int unsigned CntW  = $clog2(DELAY + 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              wr_q, wr_d;
  logic [LineW-1:0]  din_q, din_d;
  logic              accept;
  logic              last;
  logic              unused_addr;

  assign unused_addr = ^{addr[31:OffW+IdxW], addr[OffW-1:0]};

  assign accept = is_input_valid && mem_ready && (mem_read ^ mem_write);
  assign last   = (state_q == StBusy) && (cnt_q == CntW'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StRespond: state_d = accept ? StBusy : StIdle;
      StBusy: begin
        if (cnt_q == CntW'(1)) begin
          state_d = wr_q ? StIdle : StRespond;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_ready       = (state_q != StBusy);
    is_output_valid = (state_q == StRespond);
  end

  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    wr_d  = wr_q;
    din_d = din_q;
    if (accept) begin
      cnt_d = CntW'(DELAY);
      idx_d = addr[OffW+IdxW-1:OffW];
      wr_d  = mem_write;
      din_d = din;
    end else if (state_q == StBusy) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      idx_q <= '0;
      wr_q  <= 1'b0;
      din_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      wr_q  <= wr_d;
      din_q <= din_d;
    end
  end

  // Reset forces IDLE asynchronously, so a pending write never reaches the store.
  line_store #(
    .NumLines (NUM_LINES),
    .Width    (LineW)
  ) u_store (
    .clk_i   (clk),
    .rst_ni  (reset),
    .we_i    (last && wr_q),
    .waddr_i (idx_q),
    .wdata_i (din_q),
    .re_i    (last && !wr_q),
    .raddr_i (idx_q),
    .rdata_o (dout)
  );

endmodule

// File: tb/tb_line_memory.sv
// Scoreboard bench for line_memory with DELAY=4, BLOCK_SIZE=16.
module tb_line_memory;
  import line_memory_pkg::*;

  localparam int unsigned DL = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ivalid = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = '0;
  line_t       din = '0;
  logic        ovalid;
  logic        ready;
  line_t       dout;

  int    n_checks = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    pulse_n = 0;
  int    t_pulse[$];
  line_t exp_q[$];

  always #5 clk = ~clk;

  line_memory #(
    .BLOCK_SIZE (16),
    .NUM_LINES  (256),
    .DELAY      (DL)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .is_input_valid  (ivalid),
    .addr            (addr),
    .mem_read        (rd),
    .mem_write       (wr),
    .din             (din),
    .is_output_valid (ovalid),
    .dout            (dout),
    .mem_ready       (ready)
  );

  task automatic check(input string name, input line_t act, input line_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every output pulse pops one expected line.
  initial forever begin
    @(negedge clk);
    if (reset && ovalid) begin
      pulse_n++;
      t_pulse.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got dout %h, expected no pulse", dout);
      end else begin
        check("read_data", dout, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic r, input logic w, input logic [31:0] a, input line_t d);
    ivalid = 1'b1;
    rd     = r;
    wr     = w;
    addr   = a;
    din    = d;
    step();
    ivalid = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    addr   = $urandom;
    din    = {4{$urandom}};
  endtask

  task automatic chk_ready(input string name, input logic v);
    @(negedge clk);
    check(name, line_t'(ready), line_t'(v));
    step();
  endtask

  task automatic wait_ovalid(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (ovalid) seen = 1'b1;
    end
    check(name, line_t'(seen), line_t'(1));
    step();
  endtask

  initial begin
    line_t pat_a5 = {16{8'hA5}};
    line_t pat_c3 = {16{8'hC3}};
    line_t pat_5a = {16{8'h5A}};
    line_t pat_77 = {16{8'h77}};
    int    base;

    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("reset_ready", line_t'(ready), line_t'(1));
    check("reset_ovalid", line_t'(ovalid), line_t'(0));
    check("reset_dout", dout, '0);
    step();

    // Preload lines 3 and 5.
    send(1'b0, 1'b1, 32'h0000_0030, pat_c3);
    repeat (DL) step();
    send(1'b0, 1'b1, 32'h0000_0055, pat_5a);
    repeat (DL) step();

    // Write line 0x12: busy through E4, ready after.
    send(1'b0, 1'b1, 32'h0000_0120, pat_a5);
    for (int i = 0; i < 4; i++) chk_ready("write_busy", 1'b0);
    chk_ready("write_done", 1'b1);

    // Read same line via a different offset.
    exp_q.push_back(pat_a5);
    send(1'b1, 1'b0, 32'h0000_012C, '0);
    for (int i = 0; i < 4; i++) chk_ready("read_busy", 1'b0);
    @(negedge clk);
    check("read_pulse", line_t'(ovalid), line_t'(1));
    check("respond_ready", line_t'(ready), line_t'(1));
    step();
    @(negedge clk);
    check("pulse_single", line_t'(ovalid), line_t'(0));
    step();

    // Back-to-back reads; second held valid through BUSY.
    base = pulse_n;
    exp_q.push_back(pat_a5);
    exp_q.push_back(pat_5a);
    ivalid = 1'b1;
    rd     = 1'b1;
    addr   = 32'h0000_0120;
    step();
    addr   = 32'h0000_0050;
    wait_ovalid("b2b_first");
    ivalid = 1'b0;
    rd     = 1'b0;
    repeat (DL + 3) step();
    check("b2b_count", line_t'(pulse_n - base), line_t'(2));
    if (t_pulse.size() >= 2) begin
      check("b2b_spacing", line_t'(t_pulse[$] - t_pulse[$-1]), line_t'(5));
    end

    // Read and write both set: ignored.
    ivalid = 1'b1;
    rd     = 1'b1;
    wr     = 1'b1;
    addr   = 32'h0000_0070;
    for (int i = 0; i < 3; i++) chk_ready("both_ops_ignored", 1'b1);
    ivalid = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;

    // Write during BUSY must not restart the counter or overwrite.
    send(1'b0, 1'b1, 32'h0000_0070, pat_77);
    step();
    ivalid = 1'b1;
    wr     = 1'b1;
    addr   = 32'h0000_0070;
    din    = {16{8'hEE}};
    chk_ready("busy_req_e1", 1'b0);
    ivalid = 1'b0;
    wr     = 1'b0;
    chk_ready("busy_req_e2", 1'b0);
    chk_ready("busy_req_e3", 1'b0);
    chk_ready("busy_req_done", 1'b1);
    exp_q.push_back(pat_77);
    send(1'b1, 1'b0, 32'h0000_007F, '0);
    wait_ovalid("line7_read");

    // Reset at E2 of a write to line 3 discards the write.
    send(1'b0, 1'b1, 32'h0000_0030, {16{8'hFF}});
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("midreset_ready", line_t'(ready), line_t'(1));
    check("midreset_ovalid", line_t'(ovalid), line_t'(0));
    check("midreset_dout", dout, '0);
    step();
    reset = 1'b1;
    step();
    exp_q.push_back(pat_c3);
    send(1'b1, 1'b0, 32'h0000_0034, '0);
    wait_ovalid("line3_read");
    repeat (3) step();

    check("scoreboard_drained", line_t'(exp_q.size()), line_t'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
